tick_sched: RTL and testbench

Programmable clock-enable scheduler for the 50 MHz fabric clock. It generates NCH independent single-cycle enable ticks and matching 50 %-duty phase signals; consumers such as the VGA pixel pipeline, the accelerometer SPI poller and display refresh run off these on `clk` rather than off derived clocks. Divisors and enables are reconfigured at runtime through a req/ack port. New settings are shadowed and applied only at a channel's period boundary, so no tick is ever shortened or duplicated.

---
 rtl/tick_sched.sv | 80 ++++++++
 tb/tb_tick_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
// tick_sched: programmable per-channel clock-enable ticks with shadowed runtime reconfiguration
module tick_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int NCH      = 4,
    parameter int CW       = 26,
    parameter int RST_DIV  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_req,
    input  logic [2:0]     cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic           cfg_ack,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] phase
);

    if (NCH < 1 || NCH > 8 || CLK_FREQ < 1 || RST_DIV < 1) begin : g_bad_params
        $error("tick_sched: parameter out of range");
    end

    logic wr;
    logic [CW-1:0] div_in;

    // a request is taken only when no ack is in flight, so acks are at most every other cycle
    assign wr     = cfg_req && !cfg_ack;
    assign div_in = (cfg_div == '0) ? CW'(1) : cfg_div;

    // one-cycle acceptance pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cfg_ack <= 1'b0;
        else     cfg_ack <= wr;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0] div_a, div_s, cnt;
        logic          en_a, en_s, pend_r, tick_r, phase_r;
        logic          wrap, apply, sel;

        assign wrap  = en_a && (cnt == div_a - CW'(1));
        assign apply = pend_r && (wrap || !en_a);
        assign sel   = wr && (cfg_ch == 3'(c));

        assign pending[c] = pend_r;
        assign tick[c]    = tick_r;
        assign phase[c]   = phase_r;

        // counter, tick/phase generation and boundary-aligned swap of shadow into active settings
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_a   <= CW'(RST_DIV);
                en_a    <= 1'b1;
                cnt     <= '0;
                div_s   <= CW'(RST_DIV);
                en_s    <= 1'b1;
                pend_r  <= 1'b0;
                tick_r  <= 1'b0;
                phase_r <= 1'b0;
            end else begin
                tick_r <= wrap;
                if (wrap) phase_r <= !phase_r;
                if (apply) begin
                    div_a <= div_s;
                    en_a  <= en_s;
                    cnt   <= '0;
                end else begin
                    cnt <= (en_a && !wrap) ? cnt + CW'(1) : '0;
                end
                if (sel) begin
                    div_s <= div_in;
                    en_s  <= cfg_en;
                end
                pend_r <= sel || (pend_r && !apply);
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: randomized bench against an event-time reference model of tick_sched
module tb_tick_sched;
    localparam int NCH = 4;
    localparam int CW = 26;
    localparam int RST_DIV = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_req = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_en = 1'b0;
    logic           cfg_ack;
    logic [NCH-1:0] pending, tick, phase;

    int checks = 0;
    int errors = 0;
    int e = 0;

    // model: per channel the absolute edge number of the next wrap
    int           m_div [NCH];
    int           m_sdiv[NCH];
    int           m_nxt [NCH];
    bit [NCH-1:0] m_en, m_sen, m_pend, m_ph, m_tick;
    bit           m_ack;

    always #5 clk = ~clk;

    tick_sched #(.CLK_FREQ(50_000_000), .NCH(NCH), .CW(CW), .RST_DIV(RST_DIV)) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .cfg_ack(cfg_ack), .pending(pending), .tick(tick), .phase(phase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = RST_DIV;
            m_sdiv[c] = RST_DIV;
            m_nxt[c]  = RST_DIV;
        end
        m_en = '1;
        m_sen = '1;
        m_pend = '0;
        m_ph = '0;
        m_tick = '0;
        m_ack = 1'b0;
        e = 0;
    endtask

    task automatic model_edge();
        bit wr, wrap;
        wr = cfg_req && !m_ack;
        e++;
        for (int c = 0; c < NCH; c++) begin
            wrap = m_en[c] && (e == m_nxt[c]);
            m_tick[c] = wrap;
            if (wrap) m_ph[c] = !m_ph[c];
            if (m_pend[c] && (wrap || !m_en[c])) begin
                m_div[c]  = m_sdiv[c];
                m_en[c]   = m_sen[c];
                m_pend[c] = 1'b0;
                m_nxt[c]  = e + m_div[c];
            end else if (wrap) begin
                m_nxt[c] = e + m_div[c];
            end
            if (wr && int'(cfg_ch) == c) begin
                m_sdiv[c] = (cfg_div == '0) ? 1 : int'(cfg_div);
                m_sen[c]  = cfg_en;
                m_pend[c] = 1'b1;
            end
        end
        m_ack = wr;
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        check("tick", 32'(tick), 32'(m_tick));
        check("phase", 32'(phase), 32'(m_ph));
        check("pending", 32'(pending), 32'(m_pend));
        check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int ch, input int div, input bit en, input int hold);
        int n;
        cfg_ch  = 3'(ch);
        cfg_div = CW'(div);
        cfg_en  = en;
        cfg_req = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!cfg_ack && n < 8);
        if (!cfg_ack) check("ack_timeout", 32'(cfg_ack), 32'd1);
        steps(hold);
        cfg_req = 1'b0;
    endtask

    task automatic do_reset();
        cfg_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ack", 32'(cfg_ack), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check("init_tick", 32'(tick), 32'd0);
        check("init_ack", 32'(cfg_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        steps(12);
        steps(1);
        cfg(1, 5, 1'b1, 0);
        steps(20);
        cfg(2, 3, 1'b0, 0);
        steps(10);
        cfg(2, 3, 1'b1, 0);
        steps(15);
        cfg(0, 9, 1'b1, 0);
        steps(12);
        cfg(0, 7, 1'b1, 0);
        cfg(0, 4, 1'b1, 0);
        steps(20);
        cfg(3, 0, 1'b1, 0);
        steps(6);
        cfg(6, 5, 1'b0, 0);
        steps(6);
        cfg(1, 8, 1'b1, 0);
        do_reset();
        steps(12);
        for (int i = 0; i < 150; i++) begin
            steps($urandom_range(0, 12));
            cfg($urandom_range(0, 7), $urandom_range(0, 9), ($urandom % 4) != 0, $urandom_range(0, 2));
            if (i == 75) begin
                do_reset();
                steps(10);
            end
        end
        steps(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
